md_ctrl: RTL and testbench
==========================

Name: md_ctrl

Overview:
- Multiply/divide controller for the EX stage.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from the decoded EX instruction and sequences a fixed-latency multi-cycle operation.
- Owns the architectural Hi/Lo registers and raises a stall to the hazard unit while the unit is busy.
- Drives Hi, Lo and a read-select (MfSel) consumed by the EX/MEM pipeline register.

Parameters:
- MULT_LAT, 5: cycles Busy stays high for MULT/MULTU (>=1)
- DIV_LAT, 10: cycles Busy stays high for DIV/DIVU (>=1)
- CNT_W, 4: width of the latency counter; must hold max(MULT_LAT, DIV_LAT)

Ports:
- Clk  in  1  rising-edge clock
- Reset_n  in  1  asynchronous active-low reset
- Start  in  1  EX holds a valid MD-class instruction this cycle
- MdOp  in  4  operation code, encoding in md_pkg
- A  in  32  rs operand (forwarded)
- B  in  32  rt operand (forwarded)
- Busy  out  1  multi-cycle operation in flight
- Stall  out  1  freeze IF/ID/EX, bubble into MEM
- MfSel  out  2  00 none, 01 select Hi, 10 select Lo
- Hi  out  32  architectural Hi register
- Lo  out  32  architectural Lo register

Behaviour:
- Reset (async, Reset_n=0): state IDLE, counter 0, Hi=0, Lo=0, pending results 0, Busy=0. Stall and MfSel follow combinationally from inputs and state.
- States: IDLE, RUN.
- IDLE + Start + MULT/MULTU/DIV/DIVU (edge T):
  - Compute the 64-bit result into pending registers.
  - Load the counter with MULT_LAT-1 or DIV_LAT-1.
  - Go to RUN.
  - Busy=1 from T+1.
- RUN:
  - Counter decrements each edge.
  - On the edge where the counter is 0: Hi/Lo take the pending values, state returns to IDLE, Busy drops in the same cycle the new Hi/Lo become visible.
  - Net effect: an op issued at edge T gives Busy high for exactly LAT cycles; new Hi/Lo are readable at T+LAT+1.
- Arithmetic:
  - MULT is signed 32x32->64, MULTU unsigned. Hi = result[63:32], Lo = result[31:0].
  - DIV: Lo = quotient truncated toward zero, Hi = remainder with the sign of A. DIVU is unsigned.
  - Divide by zero (B==0): Hi=A, Lo=32'hFFFF_FFFF. Same latency as any divide.
  - Signed overflow (A=32'h8000_0000, B=-1): Lo=32'h8000_0000, Hi=0.
- MTHI/MTLO in IDLE with Start: Hi (resp. Lo) <= A at the next edge. Single cycle, no Busy.
- MFHI/MFLO in IDLE with Start: MfSel = 01 / 10 combinationally in the same cycle. Otherwise MfSel=00.
- Stall = Start && Busy && (MdOp != NOP).
  - While stalled, the controller ignores the op: no latch, no Hi/Lo write, MfSel=00.
  - Upstream holds the instruction until Stall drops.
- A Start with a non-MD op (NOP) never stalls, even while Busy.
- A new op in the first cycle with Busy=0 (after completion) is accepted normally. An MFHI there returns the freshly written Hi.
- Reset asserted during RUN aborts the operation; pending results are discarded.
- Undefined MdOp values are treated as NOP.

Decomposition:
- md_pkg holds:
  - MdOp encoding: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8
  - MfSel codes
  - state encoding
- One sub-module, md_arith: purely combinational 64-bit multiply/divide result, including the divide-by-zero and overflow cases. md_ctrl instantiates it and registers its output at issue.

Test Plan:
- Reset then MULT A=32'hFFFF_FFFF (-1), B=3 at edge T -> Busy high T+1..T+5; Hi=32'hFFFF_FFFF, Lo=32'hFFFF_FFFD at T+6.
- MULTU A=32'hFFFF_FFFF, B=2 -> Hi=1, Lo=32'hFFFF_FFFE after MULT_LAT.
- DIV A=-7 (32'hFFFF_FFF9), B=2 -> Lo=32'hFFFF_FFFD (-3), Hi=32'hFFFF_FFFF (-1) after 10 Busy cycles. DIVU A=7, B=0 -> Hi=7, Lo=32'hFFFF_FFFF.
- MFLO presented with Start during Busy -> Stall=1 and MfSel=00 every busy cycle; first non-busy cycle -> Stall=0, MfSel=10, Lo already holds the new value.
- MTHI A=32'h1234_5678 in IDLE -> Hi=32'h1234_5678 next edge, Busy never asserts; back-to-back MTLO A=5 next cycle -> Lo=5.
- DIV issued, Reset_n pulsed low at 4th Busy cycle -> Busy=0, Hi=Lo=0 immediately (asynchronous); a subsequent MULT 2x3 gives Lo=6, Hi=0.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide controller: operation codes,
// Hi/Lo read-select codes, controller states and an op-code sanitiser.
package md_pkg;

    typedef enum logic [3:0] {
        MD_NOP   = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_e;

    typedef enum logic [1:0] {
        MF_NONE = 2'b00,
        MF_HI   = 2'b01,
        MF_LO   = 2'b10
    } mf_sel_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // Codes above MFLO are not MD instructions; fold them onto NOP so they
    // can neither start an operation nor stall the pipe.
    function automatic md_op_e decode_op(input logic [3:0] raw);
        if (raw > 4'd8) begin
            return MD_NOP;
        end
        return md_op_e'(raw);
    endfunction

endpackage

// File: rtl/md_if.sv
// EX-stage <-> multiply/divide controller signal bundle.
interface md_if;
    import md_pkg::*;

    logic        Start;
    logic [3:0]  MdOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic        Stall;
    mf_sel_e     MfSel;
    logic [31:0] Hi;
    logic [31:0] Lo;

    // EX stage side: presents the instruction, consumes status and Hi/Lo.
    modport master (
        output Start, MdOp, A, B,
        input  Busy, Stall, MfSel, Hi, Lo
    );

    // Controller side.
    modport slave (
        input  Start, MdOp, A, B,
        output Busy, Stall, MfSel, Hi, Lo
    );

endinterface

// File: rtl/md_arith.sv
// Combinational 64-bit multiply/divide datapath. Result is {Hi, Lo}.
// Divide follows truncate-toward-zero with remainder taking the sign of A;
// divide by zero yields Hi=A, Lo=all ones.
module md_arith
    import md_pkg::*;
(
    input  md_op_e      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result
);

    logic        a_neg;
    logic        b_neg;
    logic        b_zero;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] uq;
    logic [31:0] ur;

    // Signed divide works on magnitudes and restores signs afterwards.
    // 0x8000_0000 / -1 falls out naturally: magnitude quotient 0x8000_0000
    // with equal signs, remainder 0.
    always_comb begin
        a_neg  = a[31];
        b_neg  = b[31];
        b_zero = (b == 32'd0);
        a_mag  = a_neg ? (32'd0 - a) : a;
        b_mag  = b_neg ? (32'd0 - b) : b;
        q_mag  = b_zero ? 32'd0 : (a_mag / b_mag);
        r_mag  = b_zero ? 32'd0 : (a_mag % b_mag);
        uq     = b_zero ? 32'd0 : (a / b);
        ur     = b_zero ? 32'd0 : (a % b);
        result = 64'd0;
        case (op)
            MD_MULT:  result = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            MD_MULTU: result = {32'd0, a} * {32'd0, b};
            MD_DIV: begin
                if (b_zero) begin
                    result = {a, 32'hFFFF_FFFF};
                end else begin
                    result = {(a_neg ? (32'd0 - r_mag) : r_mag),
                              ((a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag)};
                end
            end
            MD_DIVU: begin
                if (b_zero) begin
                    result = {a, 32'hFFFF_FFFF};
                end else begin
                    result = {ur, uq};
                end
            end
            default: result = 64'd0;
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide controller for the EX stage. Owns Hi/Lo, sequences a
// fixed-latency operation whose result is computed at issue and held in
// pending registers until the latency counter expires.
module md_ctrl
    import md_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic Clk,
    input  logic Reset_n,
    md_if.slave  bus
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);

    md_state_e        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [31:0]      hi_reg, hi_next;
    logic [31:0]      lo_reg, lo_next;
    logic [31:0]      pend_hi_reg, pend_hi_next;
    logic [31:0]      pend_lo_reg, pend_lo_next;
    md_op_e           op;
    logic             busy;
    mf_sel_e          mf_sel;
    logic [63:0]      arith_result;

    assign op   = decode_op(bus.MdOp);
    assign busy = (state_reg == ST_RUN);

    md_arith u_arith (
        .op     (op),
        .a      (bus.A),
        .b      (bus.B),
        .result (arith_result)
    );

    // State, counter, architectural and pending registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            hi_reg      <= 32'd0;
            lo_reg      <= 32'd0;
            pend_hi_reg <= 32'd0;
            pend_lo_reg <= 32'd0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
            pend_hi_reg <= pend_hi_next;
            pend_lo_reg <= pend_lo_next;
        end
    end

    // Next-state and read-select: ops are only accepted in IDLE, so anything
    // presented while RUN is ignored (and stalled if it is an MD op).
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        pend_hi_next = pend_hi_reg;
        pend_lo_next = pend_lo_reg;
        mf_sel       = MF_NONE;
        case (state_reg)
            ST_IDLE: begin
                if (bus.Start) begin
                    case (op)
                        MD_MULT, MD_MULTU: begin
                            pend_hi_next = arith_result[63:32];
                            pend_lo_next = arith_result[31:0];
                            cnt_next     = MULT_LOAD;
                            state_next   = ST_RUN;
                        end
                        MD_DIV, MD_DIVU: begin
                            pend_hi_next = arith_result[63:32];
                            pend_lo_next = arith_result[31:0];
                            cnt_next     = DIV_LOAD;
                            state_next   = ST_RUN;
                        end
                        MD_MTHI: hi_next = bus.A;
                        MD_MTLO: lo_next = bus.A;
                        MD_MFHI: mf_sel  = MF_HI;
                        MD_MFLO: mf_sel  = MF_LO;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (cnt_reg == '0) begin
                    hi_next    = pend_hi_reg;
                    lo_next    = pend_lo_reg;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.Busy  = busy;
    assign bus.Stall = bus.Start && busy && (op != MD_NOP);
    assign bus.MfSel = mf_sel;
    assign bus.Hi    = hi_reg;
    assign bus.Lo    = lo_reg;

endmodule

// File: tb/tb_md_ctrl.sv
// Directed plus random stimulus for md_ctrl, checked every cycle against a
// time-based reference model: an op accepted in cycle c keeps Busy high for
// cycles c+1..c+LAT and its result becomes visible in cycle c+LAT+1.
module tb_md_ctrl;
    import md_pkg::*;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    md_if bus ();

    md_ctrl #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (4)
    ) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    logic [31:0] m_hi   = 32'd0;
    logic [31:0] m_lo   = 32'd0;
    logic [31:0] m_pend_hi = 32'd0;
    logic [31:0] m_pend_lo = 32'd0;
    int          m_commit  = -1;
    logic        obs_busy  = 1'b0;
    logic        last_stall = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic straight from the instruction semantics.
    function automatic logic [63:0] ref_result(input int op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            1: begin q = sa * sb; return 64'(q); end
            2: begin uq = ua * ub; return 64'(uq); end
            3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            4: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
            default: return 64'd0;
        endcase
    endfunction

    // One clock cycle: drive inputs after the falling edge, check, advance.
    task automatic step(input logic start, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic        exp_busy;
        logic        exp_stall;
        logic [1:0]  exp_mf;
        logic [63:0] r;
        int          opi;
        opi = int'(op);
        if (opi > 8) opi = 0;
        if (m_commit == cyc) begin
            m_hi = m_pend_hi;
            m_lo = m_pend_lo;
            m_commit = -1;
        end
        exp_busy  = (m_commit != -1);
        exp_stall = start && exp_busy && (opi != 0);
        exp_mf    = 2'b00;
        if (start && !exp_busy && opi == 7) exp_mf = 2'b01;
        if (start && !exp_busy && opi == 8) exp_mf = 2'b10;
        bus.Start = start;
        bus.MdOp  = op;
        bus.A     = a;
        bus.B     = b;
        #1;
        chk("busy",  32'(bus.Busy),  32'(exp_busy));
        chk("stall", 32'(bus.Stall), 32'(exp_stall));
        chk("mfsel", 32'(bus.MfSel), 32'(exp_mf));
        chk("hi",    bus.Hi, m_hi);
        chk("lo",    bus.Lo, m_lo);
        obs_busy   = bus.Busy;
        last_stall = exp_stall;
        if (start && opi != 0)
            $display("txn cyc=%0d op=%0d a=%h b=%h %s", cyc, opi, a, b, exp_busy ? "stalled" : "accepted");
        if (start && !exp_busy) begin
            case (opi)
                1, 2, 3, 4: begin
                    r = ref_result(opi, a, b);
                    m_pend_hi = r[63:32];
                    m_pend_lo = r[31:0];
                    m_commit  = cyc + 1 + ((opi <= 2) ? MULT_LAT : DIV_LAT);
                end
                5: m_hi = a;
                6: m_lo = a;
                default: ;
            endcase
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Issue a long op, then idle until Busy drops; counts the Busy cycles.
    task automatic run_long(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int exp_lat, input string tag);
        int n;
        n = 0;
        step(1'b1, op, a, b);
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 4'd0, 32'd0, 32'd0);
            if (!obs_busy) break;
            n++;
        end
        chk(tag, 32'(n), 32'(exp_lat));
    endtask

    initial begin
        logic        r_start;
        logic [3:0]  r_op;
        logic [31:0] r_a, r_b;
        int          sel;

        bus.Start = 1'b0;
        bus.MdOp  = 4'd0;
        bus.A     = 32'd0;
        bus.B     = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy",  32'(bus.Busy),  32'd0);
        chk("rst_stall", 32'(bus.Stall), 32'd0);
        chk("rst_mfsel", 32'(bus.MfSel), 32'd0);
        chk("rst_hi",    bus.Hi, 32'd0);
        chk("rst_lo",    bus.Lo, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Signed multiply -1 * 3
        run_long(4'd1, 32'hFFFF_FFFF, 32'd3, MULT_LAT, "mult_busy_len");
        chk("mult_hi", bus.Hi, 32'hFFFF_FFFF);
        chk("mult_lo", bus.Lo, 32'hFFFF_FFFD);

        // Unsigned multiply
        run_long(4'd2, 32'hFFFF_FFFF, 32'd2, MULT_LAT, "multu_busy_len");
        chk("multu_hi", bus.Hi, 32'd1);
        chk("multu_lo", bus.Lo, 32'hFFFF_FFFE);

        // Signed divide -7 / 2
        run_long(4'd3, 32'hFFFF_FFF9, 32'd2, DIV_LAT, "div_busy_len");
        chk("div_hi", bus.Hi, 32'hFFFF_FFFF);
        chk("div_lo", bus.Lo, 32'hFFFF_FFFD);

        // Unsigned divide by zero
        run_long(4'd4, 32'd7, 32'd0, DIV_LAT, "divu0_busy_len");
        chk("divu0_hi", bus.Hi, 32'd7);
        chk("divu0_lo", bus.Lo, 32'hFFFF_FFFF);

        // Signed overflow
        run_long(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, "divovf_busy_len");
        chk("divovf_hi", bus.Hi, 32'd0);
        chk("divovf_lo", bus.Lo, 32'h8000_0000);

        // MFLO held against a busy unit: stalls, then reads fresh Lo
        step(1'b1, 4'd3, 32'd100, 32'd7);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 4'd8, 32'd0, 32'd0);
            if (!obs_busy) break;
        end
        #1;
        chk("mflo_after_sel",   32'(bus.MfSel), 32'd2);
        chk("mflo_after_stall", 32'(bus.Stall), 32'd0);
        chk("mflo_after_lo",    bus.Lo, 32'd14);
        step(1'b0, 4'd0, 32'd0, 32'd0);

        // NOP with Start while busy never stalls
        step(1'b1, 4'd1, 32'd9, 32'd9);
        step(1'b1, 4'd0, 32'd1, 32'd1);
        step(1'b1, 4'd12, 32'd1, 32'd1);
        for (int i = 0; i < 10; i++) step(1'b0, 4'd0, 32'd0, 32'd0);

        // Back-to-back moves to Hi/Lo
        step(1'b1, 4'd5, 32'h1234_5678, 32'd0);
        step(1'b1, 4'd6, 32'd5, 32'd0);
        step(1'b0, 4'd0, 32'd0, 32'd0);
        chk("mthi_hi", bus.Hi, 32'h1234_5678);
        chk("mtlo_lo", bus.Lo, 32'd5);

        // Reset in the 4th busy cycle of a divide
        step(1'b1, 4'd3, 32'd1000, 32'd3);
        repeat (3) step(1'b0, 4'd0, 32'd0, 32'd0);
        bus.Start = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.Busy), 32'd0);
        chk("abort_hi",   bus.Hi, 32'd0);
        chk("abort_lo",   bus.Lo, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        m_commit = -1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc++;
        run_long(4'd1, 32'd2, 32'd3, MULT_LAT, "post_rst_busy_len");
        chk("post_rst_hi", bus.Hi, 32'd0);
        chk("post_rst_lo", bus.Lo, 32'd6);

        // Random traffic; a stalled instruction is held until accepted
        r_start = 1'b0;
        r_op = 4'd0;
        r_a = 32'd0;
        r_b = 32'd0;
        for (int i = 0; i < 400; i++) begin
            if (!last_stall) begin
                r_start = ($urandom_range(0, 3) != 0);
                r_op    = 4'($urandom_range(0, 15));
                r_a     = $urandom;
                r_b     = $urandom;
                sel     = $urandom_range(0, 15);
                if (sel == 0) r_b = 32'd0;
                if (sel == 1) begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
                if (sel == 2) begin r_a = $urandom_range(0, 50); r_b = $urandom_range(1, 9); end
                if (sel == 3) r_b = -($urandom_range(1, 9));
            end
            step(r_start, r_op, r_a, r_b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
